des_feistel_round: RTL and testbench
====================================

DES_FEISTEL_ROUND -- requirements
Module: des_feistel_round

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  reset; synchronous, active-high.
REQ-003 in_valid  input  1  in_L/in_R/in_key/in_last carry a round request.
REQ-004 in_ready  output  1  block accepts a request this cycle.
REQ-005 in_L  input  [32:1]  left half; index 32 = DES bit 1.
REQ-006 in_R  input  [32:1]  right half; index 32 = DES bit 1.
REQ-007 in_key  input  [48:1]  round subkey Ki; index 48 = DES bit 1.
REQ-008 in_last  input  1  round 16: suppress the half swap.
REQ-009 out_valid  output  1  out_L/out_R hold a completed round.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 out_L  output  [32:1]  next left half.
REQ-012 out_R  output  [32:1]  next right half.

Function
REQ-013 The block SHALL be a 3-stage pipeline, S1/S2/S3, each stage holding a valid bit plus data and in_last.
REQ-014 S1 SHALL register in_L, in_last and X = E(in_R) XOR in_key, where E is the FIPS 46-3 expansion table.
REQ-015 S2 SHALL split X into eight 6-bit chunks, X[48:43] to S1 through X[6:1] to S8.
REQ-016 S2 SHALL register the concatenated 32-bit S-box output, chunk 1 in the MSBs, and forward L, R and in_last.
REQ-017 S3 SHALL compute f = P(S-box output), using the FIPS 46-3 P table, and register the result.
REQ-018 When in_last = 0: out_L = R, out_R = L XOR f.
REQ-019 When in_last = 1: out_L = L XOR f, out_R = R.
REQ-020 Advance enable en = !out_valid || out_ready.
REQ-021 All stages SHALL shift together when en = 1 and hold when en = 0.
REQ-022 in_ready SHALL equal en.
REQ-023 A request SHALL be accepted on a clock edge where in_valid && in_ready.
REQ-024 Latency SHALL be 3 cycles from acceptance to out_valid when out_ready is held at 1.
REQ-025 Throughput SHALL be 1 result per cycle when out_ready is held at 1.
REQ-026 Bubbles SHALL propagate as valid = 0 and SHALL NOT be compressed.
REQ-027 With in_valid = 0 and en = 1, S1 valid SHALL load 0.
REQ-028 out_L/out_R SHALL remain stable while out_valid && !out_ready.
REQ-029 Accept and retire in the same cycle SHALL both occur with no loss or duplication.
REQ-030 Data registers SHALL load only when en = 1, regardless of the valid bit.

Reset
REQ-031 On rst = 1 at a clock edge, all stage valid bits SHALL clear to 0 and all data registers SHALL clear to 0.
REQ-032 After reset, out_valid = 0, out_L = 0 and out_R = 0.
REQ-033 Requests in flight at reset SHALL be discarded without producing output.
REQ-034 in_valid during a reset cycle SHALL be ignored.
REQ-035 in_ready SHALL be 1 in the first cycle after reset.

Structure
REQ-036 E table, P table, S1/S2/S3 stage widths and the DES bit-index mapping (index = 33 - DES bit for 32-bit vectors, 49 - DES bit for 48-bit vectors) SHALL reside in a shared package des_pkg.
REQ-037 The existing modules sbox1 through sbox8 (ports Bin[6:1], BSout[4:1]) SHALL be instantiated, one per chunk, with no new S-box tables.
REQ-038 E and P SHALL be pure wiring functions.
REQ-039 No further sub-module is required.

Verification
REQ-040 After reset, in_L = 0xCC00CCFF, in_R = 0xF0AAF0AA, in_key = 0x1B02EFFC7072, in_last = 0, out_ready = 1 -> out_valid at cycle 3, out_L = 0xF0AAF0AA, out_R = 0xEF4A6544; internal X = 0x6117BA866527, S-box output = 0x5C82B597, f = 0x234AA9BB.
REQ-041 Same vector with in_last = 1 -> out_L = 0xEF4A6544, out_R = 0xF0AAF0AA.
REQ-042 Same vector with chunk 7 = 6'b010100 -> S7 output nibble = 9 (bits [8:5] of the S-box output).
REQ-043 Eight back-to-back requests with out_ready = 1 -> eight results on consecutive cycles, in order, each matching a reference model.
REQ-044 out_ready = 0 for 5 cycles with the pipeline full -> in_ready = 0 and outputs frozen; on out_ready = 1, all three results drain in order with no loss.
REQ-045 Assert rst for 1 cycle with 2 requests in flight -> out_valid = 0 and outputs = 0 the next cycle, and no stale result ever appears.

Source files
------------

// File: rtl/des_pkg.sv
// des_pkg -- shared definitions for the DES Feistel round pipeline.
//
// Holds the half/key/S-box widths, the DES bit-numbering helpers, the
// pipeline stage record types, the E expansion and P permutation (both
// pure wiring), and the nibble-pick helper used by the S-box modules.
//
// Bit numbering: vectors are declared [W:1] with the MSB carrying DES
// bit 1, so DES bit b lives at index 33-b (32-bit) or 49-b (48-bit).
package des_pkg;

  localparam int HALF_W = 32;
  localparam int KEY_W  = 48;
  localparam int SBOX_W = 32;

  // Stage 1: left/right halves and the key-mixed expansion X.
  typedef struct packed {
    logic              valid;
    logic              last;
    logic [HALF_W:1]   l;
    logic [HALF_W:1]   r;
    logic [KEY_W:1]    x;
  } s1_t;

  // Stage 2: halves forwarded, plus the concatenated S-box output.
  typedef struct packed {
    logic              valid;
    logic              last;
    logic [HALF_W:1]   l;
    logic [HALF_W:1]   r;
    logic [SBOX_W:1]   sbox;
  } s2_t;

  // Stage 3: the finished round result presented on the outputs.
  typedef struct packed {
    logic              valid;
    logic [HALF_W:1]   outL;
    logic [HALF_W:1]   outR;
  } s3_t;

  function automatic int desIdx32(input int desBit);
    return 33 - desBit;
  endfunction

  function automatic int desIdx48(input int desBit);
    return 49 - desBit;
  endfunction

  // E expansion table written directly as index wiring (index = 33 - DES bit).
  // DES order: 32 1 2 3 4 5 | 4 5 6 7 8 9 | ... | 28 29 30 31 32 1
  function automatic logic [KEY_W:1] expandE(input logic [HALF_W:1] r);
    return {r[1],  r[32], r[31], r[30], r[29], r[28],
            r[29], r[28], r[27], r[26], r[25], r[24],
            r[25], r[24], r[23], r[22], r[21], r[20],
            r[21], r[20], r[19], r[18], r[17], r[16],
            r[17], r[16], r[15], r[14], r[13], r[12],
            r[13], r[12], r[11], r[10], r[9],  r[8],
            r[9],  r[8],  r[7],  r[6],  r[5],  r[4],
            r[5],  r[4],  r[3],  r[2],  r[1],  r[32]};
  endfunction

  // P permutation table as index wiring.
  // DES order: 16 7 20 21 29 12 28 17 1 15 23 26 5 18 31 10
  //            2 8 24 14 32 27 3 9 19 13 30 6 22 11 4 25
  function automatic logic [SBOX_W:1] permuteP(input logic [SBOX_W:1] s);
    return {s[17], s[26], s[13], s[12], s[4],  s[21], s[5],  s[16],
            s[32], s[18], s[10], s[7],  s[28], s[15], s[2],  s[23],
            s[31], s[25], s[9],  s[19], s[1],  s[6],  s[30], s[24],
            s[14], s[20], s[3],  s[27], s[11], s[22], s[29], s[8]};
  endfunction

  // S-box tables are stored as 64 nibbles, row-major, entry 0 in the MSBs.
  // Row = {b1,b6}, column = b2..b5; ~idx gives 63-idx, so the nibble base
  // is 4*(63-idx) counted from the LSB.
  function automatic logic [4:1] sboxLookup(input logic [255:0] tbl,
                                            input logic [6:1]   b);
    logic [7:0] base;
    base = {~b[6], ~b[1], ~b[5:2], 2'b00};
    return tbl[base +: 4];
  endfunction

endpackage

// File: rtl/des_feistel_round_sbox.sv
// sbox1 .. sbox8 -- the eight DES substitution boxes.
//
// Ports (each module):
//   Bin   [6:1] in   6-bit chunk, Bin[6] = first DES bit of the chunk
//   BSout [4:1] out  4-bit substitution result, BSout[4] = MSB
//
// Each table is four 16-nibble rows (row 0 first).
module sbox1 import des_pkg::*; (input logic [6:1] Bin, output logic [4:1] BSout);
  assign BSout = sboxLookup({64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
                             64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D}, Bin);
endmodule

module sbox2 import des_pkg::*; (input logic [6:1] Bin, output logic [4:1] BSout);
  assign BSout = sboxLookup({64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
                             64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9}, Bin);
endmodule

module sbox3 import des_pkg::*; (input logic [6:1] Bin, output logic [4:1] BSout);
  assign BSout = sboxLookup({64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1,
                             64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C}, Bin);
endmodule

module sbox4 import des_pkg::*; (input logic [6:1] Bin, output logic [4:1] BSout);
  assign BSout = sboxLookup({64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
                             64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E}, Bin);
endmodule

module sbox5 import des_pkg::*; (input logic [6:1] Bin, output logic [4:1] BSout);
  assign BSout = sboxLookup({64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
                             64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453}, Bin);
endmodule

module sbox6 import des_pkg::*; (input logic [6:1] Bin, output logic [4:1] BSout);
  assign BSout = sboxLookup({64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
                             64'h9EF528C3704A1DB6, 64'h432C95FABE17608D}, Bin);
endmodule

module sbox7 import des_pkg::*; (input logic [6:1] Bin, output logic [4:1] BSout);
  assign BSout = sboxLookup({64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
                             64'h14BDC37EAF680592, 64'h6BD814A7950FE23C}, Bin);
endmodule

module sbox8 import des_pkg::*; (input logic [6:1] Bin, output logic [4:1] BSout);
  assign BSout = sboxLookup({64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
                             64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}, Bin);
endmodule

// File: rtl/des_feistel_round.sv
// des_feistel_round -- one DES Feistel round as a 3-stage valid/ready pipeline.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   request present on in_L/in_R/in_key/in_last
//   in_ready   out  request accepted on this edge (equals advance enable)
//   in_L/in_R  in   [32:1] halves, index 32 = DES bit 1
//   in_key     in   [48:1] round subkey, index 48 = DES bit 1
//   in_last    in   final round: no half swap
//   out_valid  out  out_L/out_R hold a completed round
//   out_ready  in   consumer takes the result on this edge
//   out_L/out_R out [32:1] next halves
//
// S1 = E(R) ^ K, S2 = S-box substitution, S3 = P permutation plus swap/XOR.
module des_feistel_round
  import des_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [HALF_W:1] in_L,
  input  logic [HALF_W:1] in_R,
  input  logic [KEY_W:1]  in_key,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [HALF_W:1] out_L,
  output logic [HALF_W:1] out_R
);

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;

  logic            en;
  logic [SBOX_W:1] sboxOut;
  logic [SBOX_W:1] fVal;

  // The whole pipe moves as one; it only stalls when a finished result is
  // waiting on a consumer that is not ready, so bubbles are never squeezed out.
  assign en        = !s3_q.valid || out_ready;
  assign in_ready  = en;
  assign out_valid = s3_q.valid;
  assign out_L     = s3_q.outL;
  assign out_R     = s3_q.outR;

  // Chunk k of X feeds sbox k; chunk 1 is the top six bits and its nibble
  // lands in the top of the substitution result.
  sbox1 u_sbox1 (.Bin(s1_q.x[48:43]), .BSout(sboxOut[32:29]));
  sbox2 u_sbox2 (.Bin(s1_q.x[42:37]), .BSout(sboxOut[28:25]));
  sbox3 u_sbox3 (.Bin(s1_q.x[36:31]), .BSout(sboxOut[24:21]));
  sbox4 u_sbox4 (.Bin(s1_q.x[30:25]), .BSout(sboxOut[20:17]));
  sbox5 u_sbox5 (.Bin(s1_q.x[24:19]), .BSout(sboxOut[16:13]));
  sbox6 u_sbox6 (.Bin(s1_q.x[18:13]), .BSout(sboxOut[12:9]));
  sbox7 u_sbox7 (.Bin(s1_q.x[12:7]),  .BSout(sboxOut[8:5]));
  sbox8 u_sbox8 (.Bin(s1_q.x[6:1]),   .BSout(sboxOut[4:1]));

  assign fVal = permuteP(s2_q.sbox);

  // Next-state for every stage. The final round keeps the halves in place
  // instead of swapping them.
  always_comb begin
    s1_d       = '0;
    s1_d.valid = in_valid;
    s1_d.last  = in_last;
    s1_d.l     = in_L;
    s1_d.r     = in_R;
    s1_d.x     = expandE(in_R) ^ in_key;

    s2_d       = '0;
    s2_d.valid = s1_q.valid;
    s2_d.last  = s1_q.last;
    s2_d.l     = s1_q.l;
    s2_d.r     = s1_q.r;
    s2_d.sbox  = sboxOut;

    s3_d       = '0;
    s3_d.valid = s2_q.valid;
    if (s2_q.last) begin
      s3_d.outL = s2_q.l ^ fVal;
      s3_d.outR = s2_q.r;
    end else begin
      s3_d.outL = s2_q.r;
      s3_d.outR = s2_q.l ^ fVal;
    end
  end

  // Data loads with the enable whether or not the stage is valid; reset
  // wipes both valid bits and data so nothing stale can surface later.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else if (en) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

endmodule

// File: tb/tb_des_feistel_round.sv
// tb_des_feistel_round -- self-checking bench for des_feistel_round.
//
// A negedge monitor pushes a reference-model result for every accepted
// request and pops/compares on every retired result; the initial block
// walks through directed steps with point checks on timing and values.
module tb_des_feistel_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [32:1] in_L;
  logic [32:1] in_R;
  logic [48:1] in_key;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [32:1] out_L;
  logic [32:1] out_R;

  int checks  = 0;
  int errors  = 0;
  int pushed  = 0;
  int retired = 0;
  int flushed = 0;

  logic [63:0] sbQ[$];

  // Reference S-boxes, row-major, entry 0 in the MSBs.
  localparam logic [255:0] TB_S [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  localparam int TB_P [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                               2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

  des_feistel_round dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_L      (in_L),
    .in_R      (in_R),
    .in_key    (in_key),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_L     (out_L),
    .out_R     (out_R)
  );

  always #5 clk = ~clk;

  // Reference round: E built arithmetically (groups of 4 with wrap-around
  // neighbours), S-boxes by row/column lookup, P by table. MSB = DES bit 1.
  function automatic logic [63:0] modelRound(input logic [31:0] l, input logic [31:0] r,
                                             input logic [47:0] k, input logic last);
    logic [47:0]  x;
    logic [31:0]  s;
    logic [31:0]  f;
    logic [31:0]  tmp;
    logic [47:0]  tmpX;
    logic [5:0]   chunk;
    logic [5:0]   idx;
    logic [255:0] t;
    int           src;
    x = '0;
    for (int j = 1; j <= 48; j++) begin
      src = 4 * ((j - 1) / 6) + (j - 1) % 6;
      if (src == 0) src = 32;
      else if (src == 33) src = 1;
      tmp = r >> (32 - src);
      x = {x[46:0], tmp[0]};
    end
    x = x ^ k;
    s = '0;
    for (int c = 0; c < 8; c++) begin
      tmpX  = x >> (42 - 6 * c);
      chunk = tmpX[5:0];
      idx   = {chunk[5], chunk[0], chunk[4:1]};
      t     = TB_S[3'(c)] << (4 * int'(idx));
      s     = {s[27:0], t[255:252]};
    end
    f = '0;
    for (int i = 0; i < 32; i++) begin
      tmp = s >> (32 - TB_P[5'(i)]);
      f = {f[30:0], tmp[0]};
    end
    return last ? {l ^ f, r} : {r, l ^ f};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] l, input logic [31:0] r,
                               input logic [47:0] k, input logic last);
    in_valid = 1'b1;
    in_L     = l;
    in_R     = r;
    in_key   = k;
    in_last  = last;
  endtask

  task automatic applyRandom(input logic valid);
    applyStimulus($urandom, $urandom, {16'($urandom), 32'($urandom)}, 1'($urandom_range(0, 1)));
    in_valid = valid;
  endtask

  // Bounded wait for the pipe and scoreboard to empty.
  task automatic waitIdle(input string tag);
    in_valid = 1'b0;
    for (int i = 0; i < 12 && (sbQ.size() != 0 || out_valid); i++) tick();
    checkOutput(tag, 64'(sbQ.size()), 64'd0);
  endtask

  // Drives eight slots (bit k of pat = request present) then two idle
  // cycles, checking out_valid mirrors the pattern exactly three edges later.
  task automatic runPattern(input logic [7:0] pat, input string tag);
    logic expV;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) applyRandom(pat[k[2:0]]);
      else in_valid = 1'b0;
      tick();
      expV = (k >= 2) ? pat[3'(k - 2)] : 1'b0;
      checkOutput({tag, "Valid"}, 64'(out_valid), 64'(expV));
    end
  endtask

  // Scoreboard: evaluated mid-cycle, so the values seen here are the ones
  // the DUT samples on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      flushed += sbQ.size();
      sbQ.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        assert (sbQ.size() != 0) else begin
          errors++;
          $error("[TB] FAIL sbUnexpected observed=%0h expected=none", {out_L, out_R});
        end
        if (sbQ.size() != 0) checkOutput("sbResult", {out_L, out_R}, sbQ.pop_front());
        retired++;
      end
      if (in_valid && in_ready) begin
        sbQ.push_back(modelRound(in_L, in_R, in_key, in_last));
        pushed++;
      end
    end
  end

  logic [31:0] sl [4];
  logic [31:0] sr [4];
  logic [47:0] sk [4];
  logic        slast [4];

  initial begin
    $display("[TB] des_feistel_round bench start");
    rst       = 1'b1;
    out_ready = 1'b1;
    applyStimulus(32'hDEADBEEF, 32'h12345678, 48'hABCDEF012345, 1'b0);
    tick();
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    checkOutput("rstOutValid", 64'(out_valid), 64'd0);
    checkOutput("rstOutL", 64'(out_L), 64'd0);
    checkOutput("rstOutR", 64'(out_R), 64'd0);
    checkOutput("rstInReady", 64'(in_ready), 64'd1);

    // Known-answer round with swap.
    applyStimulus(32'hCC00CCFF, 32'hF0AAF0AA, 48'h1B02EFFC7072, 1'b0);
    tick();
    in_valid = 1'b0;
    checkOutput("kaX", 64'(dut.s1_q.x), 64'h6117BA866527);
    checkOutput("kaValid1", 64'(out_valid), 64'd0);
    tick();
    checkOutput("kaSbox", 64'(dut.s2_q.sbox), 64'h5C82B597);
    checkOutput("kaS7Nibble", 64'(dut.s2_q.sbox[8:5]), 64'h9);
    checkOutput("kaF", 64'(dut.fVal), 64'h234AA9BB);
    checkOutput("kaValid2", 64'(out_valid), 64'd0);
    tick();
    checkOutput("kaValid3", 64'(out_valid), 64'd1);
    checkOutput("kaOutL", 64'(out_L), 64'hF0AAF0AA);
    checkOutput("kaOutR", 64'(out_R), 64'hEF4A6544);
    waitIdle("kaDrain");

    // Same vector as the final round: no swap.
    applyStimulus(32'hCC00CCFF, 32'hF0AAF0AA, 48'h1B02EFFC7072, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    checkOutput("lastValid", 64'(out_valid), 64'd1);
    checkOutput("lastOutL", 64'(out_L), 64'hEF4A6544);
    checkOutput("lastOutR", 64'(out_R), 64'hF0AAF0AA);
    waitIdle("lastDrain");

    // Key tweaked so chunk 7 becomes 000000 (S7 row 0, column 0 -> 4).
    applyStimulus(32'hCC00CCFF, 32'hF0AAF0AA, 48'h1B02EFFC7572, 1'b0);
    tick();
    in_valid = 1'b0;
    checkOutput("s7Chunk", 64'(dut.s1_q.x[12:7]), 64'd0);
    tick();
    checkOutput("s7ZeroNibble", 64'(dut.s2_q.sbox[8:5]), 64'h4);
    waitIdle("s7Drain");

    // Back-to-back throughput, then a pattern with bubbles.
    runPattern(8'hFF, "b2b");
    waitIdle("b2bDrain");
    runPattern(8'b1011_0101, "bubble");
    waitIdle("bubbleDrain");

    // Fill the pipe, stall the consumer, then release with a request waiting.
    for (int i = 0; i < 4; i++) begin
      sl[i]    = $urandom;
      sr[i]    = $urandom;
      sk[i]    = {16'($urandom), 32'($urandom)};
      slast[i] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(sl[i], sr[i], sk[i], slast[i]);
      tick();
    end
    applyStimulus(sl[3], sr[3], sk[3], slast[3]);
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stallInReady", 64'(in_ready), 64'd0);
      checkOutput("stallValid", 64'(out_valid), 64'd1);
      checkOutput("stallHold", {out_L, out_R}, modelRound(sl[0], sr[0], sk[0], slast[0]));
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checkOutput("releaseNext", {out_L, out_R}, modelRound(sl[1], sr[1], sk[1], slast[1]));
    waitIdle("stallDrain");

    // Reset with two requests in flight: nothing may come out afterwards.
    applyRandom(1'b1);
    tick();
    applyRandom(1'b1);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midRstValid", 64'(out_valid), 64'd0);
    checkOutput("midRstOut", {out_L, out_R}, 64'd0);
    checkOutput("midRstInReady", 64'(in_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("noStale", 64'(out_valid), 64'd0);
    end

    waitIdle("finalDrain");
    checkOutput("retireCount", 64'(retired), 64'(pushed - flushed));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
